// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from the combinational ROM and fills the IF/ID register.
// Redirects from ID, interrupt/exception vectoring, and return-address (epc) generation for $k0.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic        supervisor
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_sum;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] redir_tgt;
  logic        redirect;
  logic        take_exc;
  logic        take_irq;

  assign imem_addr  = pc;
  assign supervisor = pc[31];
  assign pc_plus4   = pc + 32'd4;

  // Branches never change the supervisor bit; the carry into bit 31 is dropped.
  assign br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign br_sum = if_id_pc_plus4 + br_off;
  assign br_tgt = {if_id_pc_plus4[31], br_sum[30:0]};
  assign j_tgt  = {if_id_pc_plus4[31:28], jump_index, 2'b00};

  assign redirect = jr | jump | branch_taken;

  always_comb begin
    redir_tgt = br_tgt;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_tgt = j_tgt;
    end
  end

  assign take_exc = exc & if_id_valid;
  assign take_irq = irq & ~pc[31];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      epc_we         <= 1'b0;
      epc            <= 32'h0;
    end else begin
      epc_we <= 1'b0;
      if (take_exc) begin
        // Return past the faulting instruction.
        pc             <= EXC_VECTOR;
        epc            <= if_id_pc_plus4;
        epc_we         <= 1'b1;
        if_id_instr    <= 32'h0;
        if_id_pc_plus4 <= 32'h0;
        if_id_valid    <= 1'b0;
      end else if (stall) begin
        // Hold everything; ID re-presents any redirect or irq next cycle.
      end else if (take_irq) begin
        // Resume at whatever would have been fetched next, redirect included.
        pc             <= IRQ_VECTOR;
        epc            <= redirect ? redir_tgt : pc;
        epc_we         <= 1'b1;
        if_id_instr    <= 32'h0;
        if_id_pc_plus4 <= 32'h0;
        if_id_valid    <= 1'b0;
      end else if (redirect) begin
        pc             <= redir_tgt;
        if_id_instr    <= 32'h0;
        if_id_pc_plus4 <= 32'h0;
        if_id_valid    <= 1'b0;
      end else begin
        pc             <= pc_plus4;
        if_id_instr    <= imem_data;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

endmodule
